// File: rtl/ring_fifo_with_two_pointers.sv
// Circular-buffer FIFO with independent write/read pointers, valid/ready on both ends,
// first-word fall-through output. Define RING_FIFO_COUNT_EN to expose the occupancy as count_o.
module ring_fifo_with_two_pointers #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             down_valid_o,
  input  logic             down_ready_i,
  output logic [WIDTH-1:0] down_data_o
`ifdef RING_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  // Handshake outputs depend on registered occupancy only, never on the peer's strobe.
  assign up_ready_o   = (count_q != CW'(DEPTH));
  assign down_valid_o = (count_q != '0);
  assign down_data_o  = mem[rd_ptr_q];

`ifdef RING_FIFO_COUNT_EN
  assign count_o = count_q;
`endif

  always_comb begin
    push     = up_valid_i && up_ready_o;
    pop      = down_valid_o && down_ready_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr_q] <= up_data_i;
    end
  end

endmodule

// File: tb/tb_ring_fifo_with_two_pointers.sv
// Self-checking bench for ring_fifo_with_two_pointers: directed vector table plus
// queue-model sequences for steady streaming and random stalls.
module tb_ring_fifo_with_two_pointers;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int NV    = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;
  logic [3:0]       count;

  int n_cmp = 0;
  int n_bad = 0;

  ring_fifo_with_two_pointers #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .up_valid_i  (up_valid),
    .up_ready_o  (up_ready),
    .up_data_i   (up_data),
    .down_valid_o(down_valid),
    .down_ready_i(down_ready),
    .down_data_o (down_data)
`ifdef RING_FIFO_COUNT_EN
    ,
    .count_o     (count)
`endif
  );

`ifndef RING_FIFO_COUNT_EN
  assign count = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       uv;
    logic [7:0] ud;
    logic       dr;
    logic       e_rdy;
    logic       e_vld;
    logic       chk_d;
    logic [7:0] e_d;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [NV];
  logic [7:0] q [$];

  function automatic vec_t mk(logic r, logic uv, logic [7:0] ud, logic dr, logic e_rdy,
                              logic e_vld, logic chk_d, logic [7:0] e_d, logic [3:0] e_cnt);
    vec_t v;
    v.rst = r; v.uv = uv; v.ud = ud; v.dr = dr; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.chk_d = chk_d; v.e_d = e_d; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle against the queue model: drive, check pre-edge outputs, update model.
  task automatic step(input logic uv, input logic [7:0] d, input logic dr, input string tag);
    logic do_push, do_pop;
    @(negedge clk);
    up_valid = uv; up_data = d; down_ready = dr;
    #1;
    chk({tag, "_rdy"}, {31'd0, up_ready}, {31'd0, q.size() < DEPTH});
    chk({tag, "_vld"}, {31'd0, down_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) chk({tag, "_data"}, {24'd0, down_data}, {24'd0, q[0]});
`ifdef RING_FIFO_COUNT_EN
    chk({tag, "_cnt"}, {28'd0, count}, q.size());
`endif
    do_push = uv && (q.size() < DEPTH);
    do_pop  = dr && (q.size() > 0);
    $display("%s: push=%0b data=%02h pop=%0b out=%02h occ=%0d", tag, do_push, d, do_pop,
             down_data, q.size());
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
  endtask

  initial begin
    // Tests 1/2/3: fill, hold head, overflow refused, pop-while-full, drain, empty corners, reset.
    tbl[0]  = mk(0, 1, 8'h11, 0, 1, 0, 0, 8'h00, 0);
    tbl[1]  = mk(0, 1, 8'h22, 0, 1, 1, 1, 8'h11, 1);
    tbl[2]  = mk(0, 1, 8'h33, 0, 1, 1, 1, 8'h11, 2);
    tbl[3]  = mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h11, 3);
    tbl[4]  = mk(0, 1, 8'h44, 0, 1, 1, 1, 8'h11, 3);
    tbl[5]  = mk(0, 1, 8'h55, 0, 1, 1, 1, 8'h11, 4);
    tbl[6]  = mk(0, 1, 8'h66, 0, 1, 1, 1, 8'h11, 5);
    tbl[7]  = mk(0, 1, 8'h77, 0, 1, 1, 1, 8'h11, 6);
    tbl[8]  = mk(0, 1, 8'h88, 0, 1, 1, 1, 8'h11, 7);
    tbl[9]  = mk(0, 1, 8'h99, 0, 0, 1, 1, 8'h11, 8);
    tbl[10] = mk(0, 1, 8'hAA, 1, 0, 1, 1, 8'h11, 8);
    tbl[11] = mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h22, 7);
    tbl[12] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h22, 7);
    tbl[13] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h33, 6);
    tbl[14] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h44, 5);
    tbl[15] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h55, 4);
    tbl[16] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h66, 3);
    tbl[17] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h77, 2);
    tbl[18] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h88, 1);
    tbl[19] = mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
    tbl[20] = mk(0, 1, 8'h5A, 1, 1, 0, 0, 8'h00, 0);
    tbl[21] = mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h5A, 1);
    tbl[22] = mk(0, 1, 8'h01, 0, 1, 1, 1, 8'h5A, 1);
    tbl[23] = mk(0, 1, 8'h02, 0, 1, 1, 1, 8'h5A, 2);
    tbl[24] = mk(0, 1, 8'h03, 0, 1, 1, 1, 8'h5A, 3);
    tbl[25] = mk(0, 1, 8'h04, 0, 1, 1, 1, 8'h5A, 4);
    tbl[26] = mk(1, 1, 8'hEE, 1, 1, 1, 1, 8'h5A, 5);
    tbl[27] = mk(0, 1, 8'hA5, 0, 1, 0, 0, 8'h00, 0);
    tbl[28] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'hA5, 1);
    tbl[29] = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0);

    rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rdy", {31'd0, up_ready}, 32'd1);
    chk("reset_vld", {31'd0, down_valid}, 32'd0);
`ifdef RING_FIFO_COUNT_EN
    chk("reset_cnt", {28'd0, count}, 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; up_valid = tbl[i].uv; up_data = tbl[i].ud; down_ready = tbl[i].dr;
      #1;
      $display("vec %0d: rst=%0b uv=%0b ud=%02h dr=%0b -> rdy=%0b vld=%0b data=%02h cnt=%0d",
               i, rst, up_valid, up_data, down_ready, up_ready, down_valid, down_data, count);
      chk($sformatf("vec%0d_rdy", i), {31'd0, up_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_vld", i), {31'd0, down_valid}, {31'd0, tbl[i].e_vld});
      if (tbl[i].chk_d)
        chk($sformatf("vec%0d_data", i), {24'd0, down_data}, {24'd0, tbl[i].e_d});
`ifdef RING_FIFO_COUNT_EN
      chk($sformatf("vec%0d_cnt", i), {28'd0, count}, {28'd0, tbl[i].e_cnt});
`endif
    end
    @(negedge clk);
    rst = 1'b0; up_valid = 1'b0; down_ready = 1'b0;

    // Test 4: half full, then push+pop every cycle for 20 cycles.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, "fill");
    for (int i = 0; i < 20; i++) step(1'b1, 8'h30 + 8'(i), 1'b1, "stream");
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, "drain4");
    chk("drain4_empty", {31'd0, down_valid}, 32'd0);

    // Test 6: random stalls on both sides against the queue model.
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, "drain6");
    chk("drain6_empty", {31'd0, down_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
